// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN = 1'b0,
    MDU = 1'b1
  } state_t;

  localparam int unsigned MDU_CYCLES_DEFAULT = 32;
  localparam logic [4:0]  REG_ZERO           = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: hazard inputs, register enables/flushes, perf counter.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        id_branch_taken;
  logic        ex_mdu_start;

  logic        pc_ena;
  logic        ifid_ena;
  logic        idex_ena;
  logic        exmem_ena;
  logic        memwb_ena;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        mdu_done;
  logic [31:0] stall_cycles;

  // Datapath side: reports hazards, obeys enables/flushes.
  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_rd,
           id_branch_taken, ex_mdu_start,
    input  pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena,
           ifid_flush, idex_flush, exmem_flush, mdu_done, stall_cycles
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_rd,
           id_branch_taken, ex_mdu_start,
    output pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena,
           ifid_flush, idex_flush, exmem_flush, mdu_done, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use compare: a load in EX writes a register the ID instruction reads.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_use_rs,
  input  logic       i_id_use_rt,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rd,
  output logic       o_lu
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = i_id_use_rs && (i_id_rs == i_ex_rd);
  assign w_rt_hit = i_id_use_rt && (i_id_rt == i_ex_rd);

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign o_lu = i_ex_mem_read && (i_ex_rd != REG_ZERO) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use, taken branch, multicycle MDU.
// Optional stall performance counter enabled by defining PIPE_PERF_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MDU_CYCLES = MDU_CYCLES_DEFAULT,
  parameter int unsigned CNT_W      = 6
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  if (MDU_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(MDU_CYCLES)) begin : g_bad_cfg
    $error("pipe_hazard_ctrl: MDU_CYCLES must be >= 2 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_CYCLES - 2);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic w_lu;
  logic w_hold;
  logic w_pc_ena;
  logic w_ifid_ena;
  logic w_idex_ena;
  logic w_exmem_ena;
  logic w_memwb_ena;
  logic w_ifid_flush;
  logic w_idex_flush;
  logic w_exmem_flush;
  logic w_mdu_done;

  load_use_detect u_lu (
    .i_id_rs       (bus.id_rs),
    .i_id_rt       (bus.id_rt),
    .i_id_use_rs   (bus.id_use_rs),
    .i_id_use_rt   (bus.id_use_rt),
    .i_ex_mem_read (bus.ex_mem_read),
    .i_ex_rd       (bus.ex_rd),
    .o_lu          (w_lu)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hold        = 1'b0;
    w_pc_ena      = 1'b1;
    w_ifid_ena    = 1'b1;
    w_idex_ena    = 1'b1;
    w_exmem_ena   = 1'b1;
    w_memwb_ena   = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;
    w_mdu_done    = 1'b0;

    if (r_state == MDU && r_cnt != '0) begin
      w_hold    = 1'b1;
      w_cnt_nxt = r_cnt - 1'b1;
    end else begin
      // The release cycle falls through to the normal RUN hazard checks,
      // but a new MDU start is only accepted from RUN.
      if (r_state == MDU) begin
        w_mdu_done  = 1'b1;
        w_state_nxt = RUN;
      end
      if (r_state == RUN && bus.ex_mdu_start) begin
        w_hold      = 1'b1;
        w_state_nxt = MDU;
        w_cnt_nxt   = CNT_LOAD;
      end else if (w_lu) begin
        w_pc_ena     = 1'b0;
        w_ifid_ena   = 1'b0;
        w_idex_flush = 1'b1;
      end else if (bus.id_branch_taken) begin
        w_ifid_flush = 1'b1;
      end
    end

    // MDU occupancy: freeze the front of the pipe, drain MEM/WB, bubble into MEM.
    if (w_hold) begin
      w_pc_ena      = 1'b0;
      w_ifid_ena    = 1'b0;
      w_idex_ena    = 1'b0;
      w_exmem_ena   = 1'b0;
      w_exmem_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.pc_ena      = w_pc_ena;
  assign bus.ifid_ena    = w_ifid_ena;
  assign bus.idex_ena    = w_idex_ena;
  assign bus.exmem_ena   = w_exmem_ena;
  assign bus.memwb_ena   = w_memwb_ena;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.idex_flush  = w_idex_flush;
  assign bus.exmem_flush = w_exmem_flush;
  assign bus.mdu_done    = w_mdu_done;

`ifdef PIPE_PERF_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (!w_pc_ena && r_stall_cycles != '1) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard cases plus randomized traffic.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MDU_N = 4;

  // Expected-output bit order: pc ifid idex exmem memwb | ifid_f idex_f exmem_f | done
  localparam logic [8:0] C_RUN   = 9'b11111_000_0;
  localparam logic [8:0] C_STALL = 9'b00001_001_0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.MDU_CYCLES(MDU_N), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [8:0]  ctl;
    logic [31:0] sc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: cycles left until the MDU release cycle (0 = free-running).
  int unsigned m_left = 0;
  logic [31:0] m_perf = '0;

  task automatic cycle(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic mr,
                       input logic [4:0] rd, input logic br, input logic md);
    exp_t        e;
    logic        lu;
    logic [8:0]  c;
    int unsigned nxt;
    @(posedge clk);
    #1;
    rst                 = r;
    bus.id_rs           = rs;
    bus.id_rt           = rt;
    bus.id_use_rs       = urs;
    bus.id_use_rt       = urt;
    bus.ex_mem_read     = mr;
    bus.ex_rd           = rd;
    bus.id_branch_taken = br;
    bus.ex_mdu_start    = md;
    if (r) begin
      m_left = 0;
      m_perf = '0;
    end
    lu  = mr && (rd != 5'd0) && ((urs && rs == rd) || (urt && rt == rd));
    c   = C_RUN;
    nxt = 0;
    if (m_left > 1) begin
      c   = C_STALL;
      nxt = m_left - 1;
    end else begin
      if (m_left == 1) c[0] = 1'b1;
      if (m_left == 0 && md) begin
        c   = C_STALL;
        nxt = MDU_N - 1;
      end else if (lu) begin
        c[8] = 1'b0;
        c[7] = 1'b0;
        c[2] = 1'b1;
      end else if (br) begin
        c[3] = 1'b1;
      end
    end
    e.ctl = c;
`ifdef PIPE_PERF_EN
    e.sc = m_perf;
`else
    e.sc = '0;
`endif
    sb_q.push_back(e);
    if (!r) begin
      m_left = nxt;
      if (!c[8] && m_perf != '1) m_perf = m_perf + 32'd1;
    end
  endtask

  task automatic quiet(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  exp_t       mon_e;
  logic [8:0] mon_act;

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e   = sb_q.pop_front();
      mon_act = {bus.pc_ena, bus.ifid_ena, bus.idex_ena, bus.exmem_ena, bus.memwb_ena,
                 bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.mdu_done};
      n_cmp++;
      if (mon_act !== mon_e.ctl) begin
        n_bad++;
        $display("FAIL ctl t=%0t actual=%b required=%b", $time, mon_act, mon_e.ctl);
      end
      n_cmp++;
      if (bus.stall_cycles !== mon_e.sc) begin
        n_bad++;
        $display("FAIL stall_cycles t=%0t actual=%0d required=%0d", $time, bus.stall_cycles, mon_e.sc);
      end
    end
  end

  initial begin
    bus.id_rs           = '0;
    bus.id_rt           = '0;
    bus.id_use_rs       = 1'b0;
    bus.id_use_rt       = 1'b0;
    bus.ex_mem_read     = 1'b0;
    bus.ex_rd           = '0;
    bus.id_branch_taken = 1'b0;
    bus.ex_mdu_start    = 1'b0;
    #2 rst = 1'b1;

    // reset, quiet and with MDU start held
    cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 4; i++) cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    quiet(2);

    // load-use on rs, then ex_rd = 0
    cycle(1'b0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    quiet(1);
    cycle(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);

    // taken branch alone, then with lu on rt
    cycle(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
    quiet(1);
    cycle(1'b0, 5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    quiet(1);

    // MDU start together with lu
    cycle(1'b0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1);
    quiet(4);

    // back-to-back MDU: start held through release, restarts afterwards
    for (int unsigned i = 0; i < 2 * MDU_N; i++) cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    quiet(4);

    // reset while the countdown sits at 2
    cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    quiet(4);

    for (int unsigned i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 49) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 11) == 0));
    end
    quiet(2);

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain actual=%0d required=0 pending entries", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
